// File: rtl/alu_if.sv
// ALU operand/result bundle: op select and operands in, registered result and flags out.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       op_code;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output op_code, operand1, operand2,
    input  result, zero, overflow
  );

  modport slave (
    input  op_code, operand1, operand2,
    output result, zero, overflow
  );
endinterface

// File: rtl/alu.sv
// Execute-stage integer ALU: funct-style op select, registered result with zero
// and signed-overflow flags, one-cycle latency, new op every cycle.
module alu #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_SLL  = 6'b000001;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;
  logic             shift_sat;
  logic             msb_a, msb_b;

  assign a         = bus.operand1;
  assign b         = bus.operand2;
  assign sum       = a + b;
  assign diff      = a - b;
  assign shamt     = b[SHW-1:0];
  // Any set bit above the low shift field means amount >= WIDTH: saturate.
  assign shift_sat = |b[WIDTH-1:SHW];
  assign msb_a     = a[WIDTH-1];
  assign msb_b     = b[WIDTH-1];

  // Next result and flags from the current op and operands.
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    unique case (bus.op_code)
      OP_ADD: begin
        result_d   = sum;
        overflow_d = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
      end
      OP_ADDU: result_d = sum;
      OP_SUB: begin
        result_d   = diff;
        overflow_d = (msb_a != msb_b) && (diff[WIDTH-1] != msb_a);
      end
      OP_SUBU: result_d = diff;
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_NOR:  result_d = ~(a | b);
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  result_d = shift_sat ? '0 : (a << shamt);
      OP_SRL:  result_d = shift_sat ? '0 : (a >> shamt);
      OP_SRA:  result_d = shift_sat ? {WIDTH{msb_a}} : WIDTH'($signed(a) >>> shamt);
      default: begin
        result_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
    zero_d = (result_d == '0);
  end

  // Output registers; synchronous reset discards the op sampled this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences for reset,
// then randomized ops against a plain-arithmetic reference model.
module tb_alu;
  localparam int WIDTH = 32;

  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] ADDU = 6'b100001;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] SUBU = 6'b100011;
  localparam logic [5:0] AND_ = 6'b100100;
  localparam logic [5:0] OR_  = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110;
  localparam logic [5:0] NOR_ = 6'b100111;
  localparam logic [5:0] SLT  = 6'b101010;
  localparam logic [5:0] SLTU = 6'b101011;
  localparam logic [5:0] SLL  = 6'b000001;
  localparam logic [5:0] SRL  = 6'b000010;
  localparam logic [5:0] SRA  = 6'b000011;
  localparam logic [5:0] UNDEF = 6'b111111;

  logic clk = 1'b0;
  logic rst;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_z;
    logic        exp_v;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add_vec(string name, logic [5:0] op, logic [31:0] a,
                                  logic [31:0] b, logic [31:0] r, logic z, logic v);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b;
    t.exp_r = r; t.exp_z = z; t.exp_v = v;
    vecs.push_back(t);
  endfunction

  // Reference: signed results in 64-bit arithmetic, overflow = out of 32-bit signed range.
  function automatic void model(input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic v);
    longint sa, sb, s, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r = '0;
    v = 1'b0;
    case (op)
      ADD:  begin s = sa + sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ADDU: begin s = ua + ub; r = s[31:0]; end
      SUB:  begin s = sa - sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      SUBU: begin s = ua - ub; r = s[31:0]; end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOR_: r = ~(a | b);
      SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
      SLL:  begin s = (ub >= 32) ? 64'd0 : (ua << ub); r = s[31:0]; end
      SRL:  begin s = (ub >= 32) ? 64'd0 : (ua >> ub); r = s[31:0]; end
      SRA:  begin s = sa >>> ((ub >= 32) ? 31 : ub); r = s[31:0]; end
      default: begin r = '0; v = 1'b0; end
    endcase
  endfunction

  task automatic check(string name, logic [31:0] er, logic ez, logic ev);
    checks++;
    if (bus.result !== er || bus.zero !== ez || bus.overflow !== ev) begin
      errors++;
      $display("FAIL %s: got result=%h zero=%b ovf=%b, want result=%h zero=%b ovf=%b",
               name, bus.result, bus.zero, bus.overflow, er, ez, ev);
    end
  endtask

  task automatic drive(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    bus.op_code  = op;
    bus.operand1 = a;
    bus.operand2 = b;
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic        ev;
    logic [5:0]  rop;
    logic [5:0]  ops [13];

    ops = '{ADD, ADDU, SUB, SUBU, AND_, OR_, XOR_, NOR_, SLT, SLTU, SLL, SRL, SRA};

    // Table: basic ops on 100/45, overflow, compares, shift boundaries, undefined op.
    add_vec("add",  ADD,  100, 45, 145, 0, 0);
    add_vec("addu", ADDU, 100, 45, 145, 0, 0);
    add_vec("sub",  SUB,  100, 45, 55, 0, 0);
    add_vec("subu", SUBU, 100, 45, 55, 0, 0);
    add_vec("and",  AND_, 100, 45, 36, 0, 0);
    add_vec("or",   OR_,  100, 45, 109, 0, 0);
    add_vec("xor",  XOR_, 100, 45, 73, 0, 0);
    add_vec("nor",  NOR_, 100, 45, 32'hFFFFFF92, 0, 0);
    add_vec("add_ovf",  ADD,  32'h7FFFFFFF, 1, 32'h80000000, 0, 1);
    add_vec("addu_novf", ADDU, 32'h7FFFFFFF, 1, 32'h80000000, 0, 0);
    add_vec("sub_ovf",  SUB,  32'h80000000, 1, 32'h7FFFFFFF, 0, 1);
    add_vec("subu_novf", SUBU, 32'h80000000, 1, 32'h7FFFFFFF, 0, 0);
    add_vec("add_negovf", ADD, 32'h80000000, 32'h80000000, 0, 1, 1);
    add_vec("sub_zero", SUB, 5, 5, 0, 1, 0);
    add_vec("slt",  SLT,  32'hFFFFFFFF, 1, 1, 0, 0);
    add_vec("sltu", SLTU, 32'hFFFFFFFF, 1, 0, 1, 0);
    add_vec("sll0",  SLL, 1, 0, 1, 0, 0);
    add_vec("sll1",  SLL, 1, 1, 2, 0, 0);
    add_vec("sll2",  SLL, 1, 2, 4, 0, 0);
    add_vec("sll3",  SLL, 1, 3, 8, 0, 0);
    add_vec("sll4",  SLL, 1, 4, 16, 0, 0);
    add_vec("sll5",  SLL, 1, 5, 32, 0, 0);
    add_vec("sll31", SLL, 1, 31, 32'h80000000, 0, 0);
    add_vec("sll32", SLL, 1, 32, 0, 1, 0);
    add_vec("sll_bigamt", SLL, 1, 32'h80000001, 0, 1, 0);
    add_vec("srl0",  SRL, 32'h80000000, 0, 32'h80000000, 0, 0);
    add_vec("srl1",  SRL, 32'h80000000, 1, 32'h40000000, 0, 0);
    add_vec("srl4",  SRL, 32'h80000000, 4, 32'h08000000, 0, 0);
    add_vec("srl31", SRL, 32'h80000000, 31, 1, 0, 0);
    add_vec("srl32", SRL, 32'h80000000, 32, 0, 1, 0);
    add_vec("sra0",  SRA, 32'h80000000, 0, 32'h80000000, 0, 0);
    add_vec("sra1",  SRA, 32'h80000000, 1, 32'hC0000000, 0, 0);
    add_vec("sra4",  SRA, 32'h80000000, 4, 32'hF8000000, 0, 0);
    add_vec("sra31", SRA, 32'h80000000, 31, 32'hFFFFFFFF, 0, 0);
    add_vec("sra32", SRA, 32'h80000000, 32, 32'hFFFFFFFF, 0, 0);
    add_vec("sra32_pos", SRA, 32'h40000000, 32, 0, 1, 0);
    add_vec("undef", UNDEF, 100, 45, 0, 1, 0);

    // Reset state.
    rst = 1'b1;
    drive(ADD, 100, 45);
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 0, 1, 0);

    // Get a nonzero overflowing result, then reset with an ADD pending.
    rst = 1'b0;
    drive(ADD, 32'h7FFFFFFF, 1);
    @(negedge clk);
    check("pre_reset_add", 32'h80000000, 0, 1);
    rst = 1'b1;
    drive(ADD, 100, 45);
    @(negedge clk);
    check("reset_discards_add", 0, 1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("add_after_reset", 145, 0, 0);

    // Directed table, one op per cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_z, vecs[i].exp_v);
    end

    // Randomized ops against the model, including small shift amounts and stray op codes.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) rop = 6'($urandom);
      else rop = ops[$urandom_range(0, 12)];
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 40);
        1: rb = ra;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'h7FFFFFFF ^ {31{ra[31]}}};
      drive(rop, ra, rb);
      model(rop, ra, rb, er, ev);
      @(negedge clk);
      check("random", er, (er == 0), ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the processor datapath, selected by a 6-bit MIPS-funct-style op code.
- Computes arithmetic, logic and shift results plus zero and signed-overflow flags.
- Operands and op code are sampled each clock; result and flags are registered, one-cycle latency.
- Sits in the execute stage between the register-operand muxes and the EX/MEM pipeline register.

Parameters:
- WIDTH, 32, datapath width in bits. Shift amount is taken from operand2[$clog2(WIDTH)-1:0] plus a saturation check on the upper bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- op_code  input  6  operation select
- operand1  input  WIDTH  first operand; value being shifted for shift ops
- operand2  input  WIDTH  second operand; shift amount for shift ops
- result  output  WIDTH  registered operation result
- zero  output  1  registered; 1 when result == 0
- overflow  output  1  registered; signed overflow of ADD/SUB

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, result=0, zero=1 and overflow=0. Reset has priority over any op in flight; the op sampled in that cycle is discarded.
- Latency: inputs sampled at rising edge N; result, zero and overflow are valid after edge N. There is no handshake and no stall, and a new op is accepted every cycle.
- Op codes (all others: result=0, overflow=0):
  - 100000 ADD: operand1+operand2. overflow=1 when both operands have the same sign and the result sign differs.
  - 100001 ADDU: operand1+operand2, overflow=0.
  - 100010 SUB: operand1-operand2. overflow=1 when the operand signs differ and the result sign differs from operand1.
  - 100011 SUBU: operand1-operand2, overflow=0.
  - 100100 AND: bitwise AND.
  - 100101 OR: bitwise OR.
  - 100110 XOR: bitwise XOR.
  - 100111 NOR: bitwise NOR.
  - 101010 SLT: signed compare, result = 1 if operand1<operand2 else 0.
  - 101011 SLTU: unsigned compare, result = 1 if operand1<operand2 else 0.
  - 000001 SLL: operand1 << operand2.
  - 000010 SRL: operand1 >> operand2, logical (zero fill).
  - 000011 SRA: operand1 >>> operand2, arithmetic (sign fill).
- Arithmetic wraps modulo 2^WIDTH. Carry-out is not reported.
- Shift amount is operand2 treated as unsigned. If any of operand2[WIDTH-1:5] is set (amount >= 32):
  - SLL and SRL give 0.
  - SRA gives all-copies of operand1[31].
- Shift by 0 returns operand1 unchanged.
- zero is computed from the new result value in the same cycle it is registered.
- overflow is 0 for every op other than ADD/SUB.
- Purely sequential outputs: no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst for one edge during a pending ADD -> result=0, zero=1, overflow=0; the op is not reflected.
- operand1=100, operand2=45, stepping one op per cycle, each result one cycle after its op:
  - ADD=145
  - ADDU=145
  - SUB=55
  - SUBU=55
  - AND=36
  - OR=109
  - XOR=73
  - NOR=0xFFFFFF92
  - Flags: zero=0 and overflow=0 throughout.
- Overflow and compares:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1. ADDU same -> overflow=0.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
  - SUB 5-5 -> 0, zero=1.
  - SLT -1,1 -> 1. SLTU -1,1 -> 0.
- SLL, operand1=1, amounts 0,1,2,3,4,5,31,32 -> 1, 2, 4, 8, 16, 32, 0x80000000, 0 (zero=1 at 32).
- SRL and SRA, operand1=0x80000000, amounts 0,1,4,31,32:
  - SRL -> 0x80000000, 0x40000000, 0x08000000, 1, 0
  - SRA -> 0x80000000, 0xC0000000, 0xF8000000, 0xFFFFFFFF, 0xFFFFFFFF
- Undefined op 111111 with operands 100, 45 -> result=0, zero=1, overflow=0.
